// File: rtl/multichan_transceiver_pkg.sv
// Shared definitions for the multichannel packet layer: header layout,
// length field width, TX/RX state encodings and small header helpers.
package multichan_transceiver_pkg;

  // Width of the length field carried in every header and on the buses.
  localparam int LEN_BIT     = 5;
  // Header byte is {length[4:0], channel[2:0]}; narrower channel indices
  // are zero-padded up to the 3-bit field.
  localparam int HDR_CH_BITS = 3;
  localparam int HDR_LEN_LSB = 3;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HDR  = 2'd1,
    TX_PAY  = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HDR  = 2'd0,
    RX_PAY  = 2'd1,
    RX_FULL = 2'd2
  } rx_state_e;

  // Saturate a requested/received length to the payload capacity.
  function automatic logic [LEN_BIT-1:0] clamp_len(input logic [LEN_BIT-1:0] len,
                                                   input logic [LEN_BIT-1:0] maxb);
    return (len > maxb) ? maxb : len;
  endfunction

  function automatic logic [7:0] make_hdr(input logic [LEN_BIT-1:0]     len,
                                          input logic [HDR_CH_BITS-1:0] ch);
    return {len, ch};
  endfunction

endpackage

// File: rtl/multichan_transceiver_rx_assembler.sv
// RX path: pops bytes from the UART receive side, parses the header,
// collects the payload into a message buffer and holds it until the
// client on the addressed channel consumes it.
module mct_rx_assembler
  import multichan_transceiver_pkg::*;
#(
  parameter int CHANNEL_BIT = 1,
  parameter int MESSAGE_BIT = 72
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       i_recv_data,
  input  logic                             i_recvable,
  output logic                             o_recv_flag,
  input  logic [(1<<CHANNEL_BIT)-1:0]      i_read_flag,
  output logic [(1<<CHANNEL_BIT)-1:0]      o_readable,
  output logic [LEN_BIT+MESSAGE_BIT-1:0]   o_read_bus,
  output logic [1:0]                       o_rx_state
);

  localparam int NCH  = 1 << CHANNEL_BIT;
  localparam int MAXB = MESSAGE_BIT / 8;
  localparam logic [LEN_BIT-1:0] MAXB_L = LEN_BIT'(MAXB);

  rx_state_e               r_state;
  rx_state_e               w_next;
  logic [CHANNEL_BIT-1:0]  r_ch;
  logic [LEN_BIT-1:0]      r_len_raw;   // length as received, drives byte count
  logic [LEN_BIT-1:0]      r_len;       // length as reported, saturated
  logic [LEN_BIT-1:0]      r_idx;       // payload bytes already popped
  logic [MESSAGE_BIT-1:0]  r_data;
  logic [MESSAGE_BIT-1:0]  w_data_merged;
  logic [LEN_BIT-1:0]      w_hdr_len;
  logic                    w_pop;
  logic                    w_consume;

  // A byte is popped whenever one is offered and the buffer is not held.
  assign w_pop      = i_recvable & (r_state != RX_FULL);
  assign w_hdr_len  = i_recv_data[7:HDR_LEN_LSB];
  assign w_consume  = (r_state == RX_FULL) & i_read_flag[r_ch];
  assign o_recv_flag = w_pop;
  assign o_rx_state  = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RX_HDR;
    else     r_state <= w_next;
  end

  // Next state: header -> payload -> full, back to header on consume.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_HDR:  if (w_pop) w_next = (w_hdr_len == '0) ? RX_FULL : RX_PAY;
      RX_PAY:  if (w_pop && (r_idx == r_len_raw - 5'd1)) w_next = RX_FULL;
      RX_FULL: if (w_consume) w_next = RX_HDR;
      default: w_next = RX_HDR;
    endcase
  end

  // Place the incoming byte at its lane; bytes beyond capacity fall through.
  always_comb begin
    w_data_merged = r_data;
    for (int i = 0; i < MAXB; i++) begin
      if (r_idx == LEN_BIT'(i)) w_data_merged[8*i +: 8] = i_recv_data;
    end
  end

  // Header capture and payload accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch      <= '0;
      r_len_raw <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
    end else if (w_pop) begin
      if (r_state == RX_HDR) begin
        r_ch      <= i_recv_data[CHANNEL_BIT-1:0];
        r_len_raw <= w_hdr_len;
        r_len     <= clamp_len(w_hdr_len, MAXB_L);
        r_idx     <= '0;
        r_data    <= '0;
      end else begin
        r_data <= w_data_merged;
        r_idx  <= r_idx + 5'd1;
      end
    end
  end

  // Pending flag per channel, masked by the consume pulse so a registered
  // one-cycle reader sees it drop in the same cycle it reads.
  always_comb begin
    o_readable = '0;
    for (int c = 0; c < NCH; c++) begin
      o_readable[c] = (r_state == RX_FULL) & (r_ch == CHANNEL_BIT'(c)) & ~i_read_flag[c];
    end
  end

  assign o_read_bus = (r_state == RX_FULL) ? {r_len, r_data} : '0;

endmodule

// File: rtl/multichan_transceiver.sv
// Packet layer between a byte UART and 2^CHANNEL_BIT message channels.
// TX frames a latched message as header + payload bytes; RX reassembles
// packets in mct_rx_assembler. The two directions share nothing.
// Handshakes: send_flag/recv_flag are single-cycle transfers that only
// assert when sendable/recvable are high in the same cycle; a client
// write is accepted when write_flag[c] and writable[c] are both high, a
// read completes when read_flag[c] and the pending message matches c.
module multichan_transceiver
  import multichan_transceiver_pkg::*;
#(
  parameter int CHANNEL_BIT = 1,
  parameter int MESSAGE_BIT = 72
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             send_flag,
  output logic [7:0]                       send_data,
  output logic                             recv_flag,
  input  logic [7:0]                       recv_data,
  input  logic                             sendable,
  input  logic                             recvable,
  input  logic [(1<<CHANNEL_BIT)-1:0]      read_flag,
  output logic [LEN_BIT+MESSAGE_BIT-1:0]   read_bus,
  input  logic [(1<<CHANNEL_BIT)-1:0]      write_flag,
  input  logic [LEN_BIT+MESSAGE_BIT-1:0]   write_bus,
  output logic [(1<<CHANNEL_BIT)-1:0]      readable,
  output logic [(1<<CHANNEL_BIT)-1:0]      writable,
  output logic [1:0]                       o_tx_state,
  output logic [1:0]                       o_rx_state
);

  localparam int NCH  = 1 << CHANNEL_BIT;
  localparam logic [LEN_BIT-1:0] MAXB_L = LEN_BIT'(MESSAGE_BIT / 8);

  tx_state_e               r_tx_state;
  tx_state_e               w_tx_next;
  logic [CHANNEL_BIT-1:0]  r_tx_ch;
  logic [LEN_BIT-1:0]      r_tx_len;
  logic [LEN_BIT-1:0]      r_tx_left;
  logic [MESSAGE_BIT-1:0]  r_tx_data;   // shifts right, next byte in [7:0]
  logic [CHANNEL_BIT-1:0]  w_wr_ch;
  logic                    w_wr_any;
  logic [LEN_BIT-1:0]      w_wr_len;

  assign w_wr_any   = |write_flag;
  assign w_wr_len   = clamp_len(write_bus[MESSAGE_BIT +: LEN_BIT], MAXB_L);
  assign o_tx_state = r_tx_state;

  // Lowest requesting channel wins when several write at once.
  always_comb begin
    w_wr_ch = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (write_flag[c]) w_wr_ch = CHANNEL_BIT'(c);
    end
  end

  // TX state register.
  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  // TX next state: advance only on cycles where the UART takes a byte.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (w_wr_any) w_tx_next = TX_HDR;
      TX_HDR:  if (sendable) w_tx_next = (r_tx_len == '0) ? TX_IDLE : TX_PAY;
      TX_PAY:  if (sendable && (r_tx_left == 5'd1)) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // Latch the message on accept, then shift out one byte per payload send.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ch   <= '0;
      r_tx_len  <= '0;
      r_tx_left <= '0;
      r_tx_data <= '0;
    end else if ((r_tx_state == TX_IDLE) && w_wr_any) begin
      r_tx_ch   <= w_wr_ch;
      r_tx_len  <= w_wr_len;
      r_tx_left <= w_wr_len;
      r_tx_data <= write_bus[MESSAGE_BIT-1:0];
    end else if ((r_tx_state == TX_PAY) && sendable) begin
      r_tx_left <= r_tx_left - 5'd1;
      r_tx_data <= r_tx_data >> 8;
    end
  end

  // Byte mux and push strobe from registered state.
  always_comb begin
    send_flag = 1'b0;
    send_data = 8'h00;
    case (r_tx_state)
      TX_HDR: begin
        send_flag = sendable;
        send_data = make_hdr(r_tx_len, HDR_CH_BITS'(r_tx_ch));
      end
      TX_PAY: begin
        send_flag = sendable;
        send_data = r_tx_data[7:0];
      end
      default: ;
    endcase
  end

  assign writable = {NCH{r_tx_state == TX_IDLE}};

  mct_rx_assembler #(
    .CHANNEL_BIT (CHANNEL_BIT),
    .MESSAGE_BIT (MESSAGE_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_recv_data (recv_data),
    .i_recvable  (recvable),
    .o_recv_flag (recv_flag),
    .i_read_flag (read_flag),
    .o_readable  (readable),
    .o_read_bus  (read_bus),
    .o_rx_state  (o_rx_state)
  );

endmodule

// File: tb/tb_multichan_transceiver.sv
// Bench for multichan_transceiver with CHANNEL_BIT=1, MESSAGE_BIT=72.
module tb_multichan_transceiver;

  localparam int MB   = 72;
  localparam int MAXB = MB / 8;
  localparam int W    = 5 + MB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         send_flag, recv_flag, sendable, recvable;
  logic [7:0]   send_data, recv_data;
  logic [1:0]   read_flag, write_flag, readable, writable;
  logic [W-1:0] read_bus, write_bus;
  logic [1:0]   o_tx_state, o_rx_state;

  multichan_transceiver #(.CHANNEL_BIT(1), .MESSAGE_BIT(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .send_flag  (send_flag),
    .send_data  (send_data),
    .recv_flag  (recv_flag),
    .recv_data  (recv_data),
    .sendable   (sendable),
    .recvable   (recvable),
    .read_flag  (read_flag),
    .read_bus   (read_bus),
    .write_flag (write_flag),
    .write_bus  (write_bus),
    .readable   (readable),
    .writable   (writable),
    .o_tx_state (o_tx_state),
    .o_rx_state (o_rx_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];    // TX bytes still expected, in order
  logic [7:0] tx_log[$];   // TX bytes actually seen
  logic [7:0] rx_fifo[$];  // emulated UART receive side
  int total = 0;
  int bad   = 0;
  int sendable_mode = 0;   // 0: always 1, 1: toggle, 2: random

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: sample at the falling edge, then drive just after the rising edge.
  task automatic step();
    logic popped;
    @(negedge clk);
    popped = recv_flag;
    if (send_flag) begin
      check("send_guard", 128'(sendable), 128'd1);
      tx_log.push_back(send_data);
      if (exp_q.size() == 0) check("tx_extra", 128'd1, 128'd0);
      else                   check("tx_byte", 128'(send_data), 128'(exp_q.pop_front()));
    end
    if (recv_flag) check("recv_guard", 128'(recvable), 128'd1);
    @(posedge clk);
    #1;
    if (popped && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
    recvable  = (rx_fifo.size() > 0);
    recv_data = recvable ? rx_fifo[0] : 8'h00;
    if (rst)                     sendable = 1'b0;
    else if (sendable_mode == 0) sendable = 1'b1;
    else if (sendable_mode == 1) sendable = ~sendable;
    else                         sendable = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1; write_flag = '0; read_flag = '0; write_bus = '0; sendable = 1'b0;
    rx_fifo.delete(); exp_q.delete();
    recvable = 1'b0; recv_data = 8'h00;
    step(); step();
    rst = 1'b0;
  endtask

  // Reference framing: header {len, 3-bit ch}, then len bytes LSB first.
  task automatic tx_write(input logic [1:0] mask, input logic [4:0] len, input logic [71:0] data);
    int ch = 0;
    int keep = (int'(len) > MAXB) ? MAXB : int'(len);
    for (int c = 1; c >= 0; c--) if (mask[c]) ch = c;
    exp_q.push_back(8'(keep * 8 + ch));
    for (int i = 0; i < keep; i++) exp_q.push_back(8'(data >> (8 * i)));
    write_flag = mask; write_bus = {len, data};
    step();
    write_flag = '0;
  endtask

  task automatic wait_tx_done();
    int n = 0;
    while ((exp_q.size() != 0 || writable != 2'b11) && n < 200) begin step(); n++; end
    check("tx_drain", 128'(exp_q.size()), 128'd0);
    check("tx_idle", 128'(writable), 128'd3);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_fifo.push_back(b);
    recvable = 1'b1; recv_data = rx_fifo[0];
  endtask

  // Queue one packet with random payload; return the message it should yield.
  task automatic rx_feed(input logic [7:0] hdr, output logic [W-1:0] exp_bus);
    int L = int'(hdr[7:3]);
    int keep = (L > MAXB) ? MAXB : L;
    logic [71:0] d = '0;
    logic [7:0] b;
    rx_push(hdr);
    for (int i = 0; i < L; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_push(b);
      if (i < keep) d = d | (72'(b) << (8 * i));
    end
    exp_bus = {5'(keep), d};
  endtask

  task automatic wait_readable();
    int n = 0;
    while (readable == 2'b00 && n < 200) begin step(); n++; end
  endtask

  // Check the pending message, consume it with a one-cycle read_flag pulse.
  task automatic rx_read(input logic [1:0] exp_rd, input logic [W-1:0] exp_bus);
    wait_readable();
    check("rx_readable", 128'(readable), 128'(exp_rd));
    check("rx_bus", 128'(read_bus), 128'(exp_bus));
    read_flag = exp_rd;
    #1;
    check("rd_mask", 128'(readable), 128'd0);
    step();
    read_flag = '0;
    check("rd_once", 128'(readable), 128'd0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [1:0]  mask;
    logic [4:0]  len;
    logic [71:0] data;
    logic [7:0]  exp_hdr;
    int          exp_bytes;
  } tx_vec_t;

  typedef struct {
    logic [7:0] hdr;
    logic [1:0] exp_rd;
    logic [4:0] exp_len;
  } rx_vec_t;

  tx_vec_t tv[7];
  rx_vec_t rv[6];
  logic [7:0] plan[6];

  initial begin
    logic [W-1:0] eb;
    logic [71:0]  rd;
    logic [7:0]   h;
    int n;
    logic rx_done;

    tv[0] = '{2'b01, 5'd5,  72'h1_0000_1004, 8'h28, 6};
    tv[1] = '{2'b10, 5'd1,  72'hAA,          8'h09, 2};
    tv[2] = '{2'b11, 5'd2,  72'hBEEF,        8'h10, 3};
    tv[3] = '{2'b10, 5'd0,  72'h1234,        8'h01, 1};
    tv[4] = '{2'b01, 5'd12, 72'h99_8877_6655_4433_2211, 8'h48, 10};
    tv[5] = '{2'b10, 5'd31, 72'hF0_E0D0_C0B0_A090_8070, 8'h49, 10};
    tv[6] = '{2'b01, 5'd9,  72'h12_3456_789A_BCDE_F012, 8'h48, 10};

    rv[0] = '{8'h09, 2'b10, 5'd1};
    rv[1] = '{8'h00, 2'b01, 5'd0};
    rv[2] = '{8'h61, 2'b10, 5'd9};
    rv[3] = '{8'h48, 2'b01, 5'd9};
    rv[4] = '{8'hF9, 2'b10, 5'd9};
    rv[5] = '{8'h0E, 2'b01, 5'd1};

    plan[0] = 8'h28; plan[1] = 8'h04; plan[2] = 8'h10;
    plan[3] = 8'h00; plan[4] = 8'h00; plan[5] = 8'h01;

    // ---- reset values ----
    do_reset();
    check("rst_send_flag", 128'(send_flag), 128'd0);
    check("rst_send_data", 128'(send_data), 128'd0);
    check("rst_recv_flag", 128'(recv_flag), 128'd0);
    check("rst_readable",  128'(readable),  128'd0);
    check("rst_writable",  128'(writable),  128'd3);
    check("rst_read_bus",  128'(read_bus),  128'd0);

    // ---- TX: back-to-back bytes, writable low throughout ----
    sendable_mode = 0; sendable = 1'b1;
    tx_log.delete();
    tx_write(2'b01, 5'd5, 72'h1_0000_1004);
    check("tx_wr_low", 128'(writable), 128'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("tx_consec", 128'(tx_log.size()), 128'(k + 1));
      check("tx_writable", 128'(writable), (k == 5) ? 128'd3 : 128'd0);
    end
    for (int i = 0; i < 6; i++)
      check("tx_plan", 128'((i < tx_log.size()) ? tx_log[i] : 8'hxx), 128'(plan[i]));

    // ---- TX: sendable toggling, 4-byte message ----
    sendable_mode = 1;
    tx_log.delete();
    tx_write(2'b10, 5'd4, 72'h44_3322_11);
    wait_tx_done();
    check("tx_toggle_cnt", 128'(tx_log.size()), 128'd5);

    // ---- TX table, with an ignored write while busy ----
    for (int i = 0; i < 7; i++) begin
      sendable_mode = i % 2; sendable = 1'b1;
      tx_log.delete();
      tx_write(tv[i].mask, tv[i].len, tv[i].data);
      write_flag = 2'b01; write_bus = {5'd3, 72'hFF_FFFF};
      step();
      write_flag = '0;
      wait_tx_done();
      check("tx_hdr", 128'((tx_log.size() > 0) ? tx_log[0] : 8'hxx), 128'(tv[i].exp_hdr));
      check("tx_cnt", 128'(tx_log.size()), 128'(tv[i].exp_bytes));
    end

    // ---- RX: DEADBEEF with exact latency ----
    sendable_mode = 0;
    rx_push(8'h20); rx_push(8'hEF); rx_push(8'hBE); rx_push(8'hAD); rx_push(8'hDE);
    for (int k = 0; k < 4; k++) step();
    check("rx_lat_early", 128'(readable), 128'd0);
    step();
    check("rx_lat", 128'(readable), 128'd1);
    rx_read(2'b01, {5'd4, 72'hDEAD_BEEF});

    // ---- RX: channel 1, wrong-channel read ignored ----
    rx_push(8'h09); rx_push(8'hAA);
    wait_readable();
    read_flag = 2'b01;
    step();
    read_flag = '0;
    check("rd_other", 128'(readable), 128'd2);
    rx_read(2'b10, {5'd1, 72'hAA});

    // ---- RX: backpressure while full ----
    rx_push(8'h08); rx_push(8'h11); rx_push(8'h10); rx_push(8'h22); rx_push(8'h33);
    wait_readable();
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_flag", 128'(recv_flag), 128'd0);
    end
    check("bp_fifo", 128'(rx_fifo.size()), 128'd3);
    rx_read(2'b01, {5'd1, 72'h11});
    rx_read(2'b01, {5'd2, 72'h3322});

    // ---- RX table with random payloads ----
    for (int i = 0; i < 6; i++) begin
      rx_feed(rv[i].hdr, eb);
      rd = eb[71:0];
      rx_read(rv[i].exp_rd, {rv[i].exp_len, rd});
    end

    // ---- reset mid-packet in both directions ----
    tx_write(2'b01, 5'd9, 72'h11_2233_4455_6677_8899);
    rx_push(8'h60);
    for (int i = 0; i < 5; i++) rx_push(8'(i + 1));
    for (int k = 0; k < 4; k++) step();
    do_reset();
    check("mid_rst_writable", 128'(writable), 128'd3);
    check("mid_rst_readable", 128'(readable), 128'd0);
    step(); step();
    check("mid_rst_quiet", 128'(tx_log.size() > 0 && send_flag), 128'd0);
    rx_push(8'h11); rx_push(8'h5A); rx_push(8'hA5);
    rx_read(2'b10, {5'd2, 72'hA55A});

    // ---- random concurrent TX and RX against the reference model ----
    sendable_mode = 2;
    for (int it = 0; it < 40; it++) begin
      h = 8'($urandom_range(0, 255));
      rx_feed(h, eb);
      tx_write(2'($urandom_range(1, 3)), 5'($urandom_range(0, 31)),
               72'({$urandom, $urandom, $urandom}));
      rx_done = 1'b0; n = 0;
      while ((!rx_done || exp_q.size() != 0 || writable != 2'b11) && n < 400) begin
        if (!rx_done && readable != 2'b00) begin
          rx_read(2'b01 << h[0], eb);
          rx_done = 1'b1;
        end else begin
          step();
        end
        n++;
      end
      check("rand_done", {126'd0, rx_done, (exp_q.size() == 0)}, 128'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
